// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALU codes, decode tables, muldiv FSM states and the ALU decode helper
package alu_ctrl_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [2:0] OP_MEM   = 3'b000;
    localparam logic [2:0] OP_BEQ   = 3'b001;
    localparam logic [2:0] OP_RTYPE = 3'b010;
    localparam logic [2:0] OP_ANDI  = 3'b011;
    localparam logic [2:0] OP_ORI   = 3'b100;
    localparam logic [2:0] OP_SLTI  = 3'b101;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_DIVU = 6'b011011;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_MTLO = 6'b010011;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    function automatic logic [3:0] alu_decode(input logic [2:0] op, input logic [5:0] f);
        logic [3:0] r;
        r = ALU_AND;
        case (op)
            OP_MEM:  r = ALU_ADD;
            OP_BEQ:  r = ALU_SUB;
            OP_ANDI: r = ALU_AND;
            OP_ORI:  r = ALU_OR;
            OP_SLTI: r = ALU_SLT;
            OP_RTYPE:
                case (f)
                    F_AND:          r = ALU_AND;
                    F_OR:           r = ALU_OR;
                    F_ADD, F_ADDU:  r = ALU_ADD;
                    F_SUB, F_SUBU:  r = ALU_SUB;
                    F_SLT:          r = ALU_SLT;
                    F_NOR:          r = ALU_NOR;
                    default:        r = ALU_AND;
                endcase
            default: r = ALU_AND;
        endcase
        return r;
    endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: radix-2 iterative multiply/divide with sign fix-up and HI/LO registers
module muldiv_iter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_mul_i,
    input  logic             start_div_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   b_q, b_d, acc_q, acc_d, x_q, x_d, hi_q, hi_d, lo_q, lo_d;
    logic               neg_q, neg_d, rneg_q, rneg_d, is_mul_q, is_mul_d;
    logic               sa, sb;
    logic [WIDTH:0]     sum, shl, diff;
    logic [2*WIDTH-1:0] prod;

    // Next-state: operand capture, one shift-add/shift-subtract step per cycle, then sign fix into HI/LO
    always_comb begin
        sa = signed_i & a_i[WIDTH-1];
        sb = signed_i & b_i[WIDTH-1];
        sum = {1'b0, acc_q} + (x_q[0] ? {1'b0, b_q} : '0);
        shl = {acc_q, x_q[WIDTH-1]};
        diff = shl - {1'b0, b_q};
        prod = {acc_q, x_q};
        state_d = state_q;
        cnt_d = cnt_q;
        b_d = b_q;
        acc_d = acc_q;
        x_d = x_q;
        neg_d = neg_q;
        rneg_d = rneg_q;
        is_mul_d = is_mul_q;
        hi_d = wr_hi_i ? wr_data_i : hi_q;
        lo_d = wr_lo_i ? wr_data_i : lo_q;
        case (state_q)
            ST_IDLE:
                if (start_mul_i || start_div_i) begin
                    state_d = start_mul_i ? ST_MUL : ST_DIV;
                    cnt_d = CNT_W'(WIDTH);
                    b_d = sb ? -b_i : b_i;
                    x_d = sa ? -a_i : a_i;
                    acc_d = '0;
                    // a zero divisor must leave the all-ones quotient unnegated
                    neg_d = (sa ^ sb) & (start_mul_i | (b_i != '0));
                    rneg_d = sa;
                    is_mul_d = start_mul_i;
                end
            ST_MUL: begin
                acc_d = sum[WIDTH:1];
                x_d = {sum[0], x_q[WIDTH-1:1]};
                cnt_d = cnt_q - 1'b1;
                state_d = cnt_q == CNT_W'(1) ? ST_FIX : ST_MUL;
            end
            ST_DIV: begin
                acc_d = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
                x_d = {x_q[WIDTH-2:0], ~diff[WIDTH]};
                cnt_d = cnt_q - 1'b1;
                state_d = cnt_q == CNT_W'(1) ? ST_FIX : ST_DIV;
            end
            default: begin
                {hi_d, lo_d} = is_mul_q ? (neg_q ? -prod : prod)
                                        : {rneg_q ? -acc_q : acc_q, neg_q ? -x_q : x_q};
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation without touching HI/LO beyond clearing
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q <= '0;
            b_q <= '0;
            acc_q <= '0;
            x_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            neg_q <= 1'b0;
            rneg_q <= 1'b0;
            is_mul_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            b_q <= b_d;
            acc_q <= acc_d;
            x_q <= x_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            neg_q <= neg_d;
            rneg_q <= rneg_d;
            is_mul_q <= is_mul_d;
        end
    end

    assign busy_o = state_q != ST_IDLE;
    assign hi_o = hi_q;
    assign lo_o = lo_q;
endmodule

// File: rtl/alu_muldiv_control.sv
// alu_muldiv_control: ALU op decode plus muldiv issue/stall control and HI/LO read mux
module alu_muldiv_control
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             valid_i,
    input  logic [2:0]       alu_op_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] rs_val_i,
    input  logic [WIDTH-1:0] rt_val_i,
    output logic [3:0]       aluctrl_o,
    output logic             stall_o,
    output logic             busy_o,
    output logic             mf_valid_o,
    output logic [WIDTH-1:0] mf_data_o
);
    logic             md, acc;
    logic [WIDTH-1:0] hi, lo;

    // Muldiv/HI/LO instructions issue only when the sequencer is idle, otherwise they hold the front end
    always_comb begin
        md = valid_i && alu_op_i == OP_RTYPE
             && (funct_i[5:2] == F_MULT[5:2] || funct_i[5:2] == F_MFHI[5:2]);
        acc = md && !busy_o;
        stall_o = md && busy_o;
        aluctrl_o = alu_decode(alu_op_i, funct_i);
        mf_valid_o = acc && (funct_i == F_MFHI || funct_i == F_MFLO);
        mf_data_o = !mf_valid_o ? '0 : funct_i == F_MFHI ? hi : lo;
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_mul_i(acc && funct_i[5:1] == F_MULT[5:1]),
        .start_div_i(acc && funct_i[5:1] == F_DIV[5:1]),
        .signed_i   (!funct_i[0]),
        .a_i        (rs_val_i),
        .b_i        (rt_val_i),
        .wr_hi_i    (acc && funct_i == F_MTHI),
        .wr_lo_i    (acc && funct_i == F_MTLO),
        .wr_data_i  (rs_val_i),
        .busy_o     (busy_o),
        .hi_o       (hi),
        .lo_o       (lo)
    );
endmodule

// File: tb/tb_alu_muldiv_control.sv
// tb_alu_muldiv_control: table-driven decode checks, directed muldiv corners and randomized muldiv vs. arithmetic model
module tb_alu_muldiv_control;
    localparam int W = 32;
    localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
    localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;

    logic         clk = 1'b0;
    logic         reset, valid;
    logic [2:0]   alu_op;
    logic [5:0]   funct;
    logic [W-1:0] rs, rt;
    logic [3:0]   aluctrl;
    logic         stall, busy, mf_valid;
    logic [W-1:0] mf_data;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [2:0] op;
        logic [5:0] f;
        logic       v;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl[$];

    alu_muldiv_control #(.WIDTH(W)) dut (
        .clk_i(clk), .reset_i(reset), .valid_i(valid), .alu_op_i(alu_op), .funct_i(funct),
        .rs_val_i(rs), .rt_val_i(rt), .aluctrl_o(aluctrl), .stall_o(stall), .busy_o(busy),
        .mf_valid_o(mf_valid), .mf_data_o(mf_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        valid = 1'b1;
        alu_op = 3'b010;
        funct = f;
        rs = a;
        rt = b;
    endtask

    task automatic rdchk(input string nm, input logic [5:0] f, input logic [W-1:0] exp);
        issue(f, '0, '0);
        #1;
        chk({nm, " mf_valid"}, 64'(mf_valid), 64'(1'b1));
        chk({nm, " mf_data"}, 64'(mf_data), 64'(exp));
        valid = 1'b0;
    endtask

    // Reference: signed/unsigned arithmetic straight from the instruction definitions
    task automatic model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint sa, sb;
        logic [63:0] p;
        int q, r;
        sa = $signed(a);
        sb = $signed(b);
        hi = '0;
        lo = '0;
        if (f == MULT || f == MULTU) begin
            p = (f == MULT) ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 0) begin
            hi = a;
            lo = '1;
        end else if (f == DIVU) begin
            hi = a % b;
            lo = a / b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            hi = '0;
            lo = a;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            hi = r;
            lo = q;
        end
    endtask

    // Present an instruction, count stall cycles until accepted, count busy cycles, then read HI/LO
    task automatic run(input string nm, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int exp_stall, input logic [W-1:0] eh, input logic [W-1:0] el);
        int n;
        issue(f, a, b);
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            step();
            #1;
        end
        chk({nm, " stall cycles"}, 64'(n), 64'(exp_stall));
        step();
        valid = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        chk({nm, " busy cycles"}, 64'(n), 64'(W + 1));
        rdchk({nm, " hi"}, MFHI, eh);
        rdchk({nm, " lo"}, MFLO, el);
    endtask

    initial begin
        logic [W-1:0] eh, el, a, b;
        logic [5:0] f;
        int stalls;
        reset = 1'b1;
        valid = 1'b0;
        alu_op = '0;
        funct = '0;
        rs = '0;
        rt = '0;
        step();
        step();
        chk("reset busy", 64'(busy), 64'(1'b0));
        chk("reset stall", 64'(stall), 64'(1'b0));
        chk("reset mf_valid", 64'(mf_valid), 64'(1'b0));
        chk("reset mf_data", 64'(mf_data), 64'(0));
        rdchk("reset hi", MFHI, '0);
        rdchk("reset lo", MFLO, '0);
        reset = 1'b0;

        tbl.push_back('{3'b000, 6'b000000, 1'b1, 4'b0010});
        tbl.push_back('{3'b000, 6'b100111, 1'b1, 4'b0010});
        tbl.push_back('{3'b001, 6'b000000, 1'b1, 4'b0110});
        tbl.push_back('{3'b011, 6'b011000, 1'b1, 4'b0000});
        tbl.push_back('{3'b100, 6'b000000, 1'b1, 4'b0001});
        tbl.push_back('{3'b101, 6'b000000, 1'b1, 4'b0111});
        tbl.push_back('{3'b110, 6'b100000, 1'b1, 4'b0000});
        tbl.push_back('{3'b111, 6'b100000, 1'b1, 4'b0000});
        tbl.push_back('{3'b010, 6'b100100, 1'b1, 4'b0000});
        tbl.push_back('{3'b010, 6'b100101, 1'b1, 4'b0001});
        tbl.push_back('{3'b010, 6'b100000, 1'b1, 4'b0010});
        tbl.push_back('{3'b010, 6'b100001, 1'b1, 4'b0010});
        tbl.push_back('{3'b010, 6'b100010, 1'b1, 4'b0110});
        tbl.push_back('{3'b010, 6'b100011, 1'b1, 4'b0110});
        tbl.push_back('{3'b010, 6'b101010, 1'b1, 4'b0111});
        tbl.push_back('{3'b010, 6'b100111, 1'b1, 4'b1100});
        tbl.push_back('{3'b010, 6'b000000, 1'b1, 4'b0000});
        tbl.push_back('{3'b010, 6'b111111, 1'b1, 4'b0000});
        tbl.push_back('{3'b010, 6'b101011, 1'b1, 4'b0000});
        tbl.push_back('{3'b010, MFHI, 1'b1, 4'b0000});
        tbl.push_back('{3'b010, MULT, 1'b0, 4'b0000});
        tbl.push_back('{3'b010, DIVU, 1'b0, 4'b0000});
        foreach (tbl[i]) begin
            valid = tbl[i].v;
            alu_op = tbl[i].op;
            funct = tbl[i].f;
            #1;
            chk($sformatf("decode op=%b f=%b aluctrl", tbl[i].op, tbl[i].f), 64'(aluctrl), 64'(tbl[i].exp));
            chk($sformatf("decode op=%b f=%b stall", tbl[i].op, tbl[i].f), 64'(stall), 64'(1'b0));
            step();
        end
        valid = 1'b0;
        chk("no start from non-rtype", 64'(busy), 64'(1'b0));

        step(); run("mult 7*-3", MULT, 32'd7, 32'hFFFF_FFFD, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        step(); run("multu max^2", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001);
        step(); run("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        step(); run("div min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 32'h8000_0000);
        step(); run("divu 10/0", DIVU, 32'd10, 32'd0, 0, 32'h0000_000A, 32'hFFFF_FFFF);
        step(); run("div -7/0", DIV, 32'hFFFF_FFF9, 32'd0, 0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        step(); run("div 100/-9", DIV, 32'd100, 32'hFFFF_FFF7, 0, 32'd1, 32'hFFFF_FFF5);

        step();
        issue(MTHI, 32'h1234_5678, '0);
        step();
        issue(MTLO, 32'h9ABC_DEF0, '0);
        step();
        valid = 1'b0;
        rdchk("mthi", MFHI, 32'h1234_5678);
        rdchk("mtlo", MFLO, 32'h9ABC_DEF0);

        step();
        issue(MULT, 32'hFFFF_FFFB, 32'd6);
        step();
        stalls = 0;
        for (int c = 1; c <= 100; c++) begin
            if (c == 5) begin
                issue(6'b100000, '0, '0);
                #1;
                chk("add during busy aluctrl", 64'(aluctrl), 64'(4'b0010));
                chk("add during busy stall", 64'(stall), 64'(1'b0));
            end else begin
                issue(MFHI, '0, '0);
                #1;
                if (!stall) break;
                stalls++;
            end
            step();
        end
        chk("mfhi stall cycles", 64'(stalls), 64'(W));
        chk("mfhi after stall mf_valid", 64'(mf_valid), 64'(1'b1));
        chk("mfhi after stall data", 64'(mf_data), 64'(32'hFFFF_FFFF));
        rdchk("mflo after stall", MFLO, 32'hFFFF_FFE2);

        step();
        issue(MULT, 32'd3, 32'd4);
        step();
        run("b2b div", DIV, 32'd100, 32'd7, W + 1, 32'd2, 32'd14);

        step();
        issue(DIV, 32'd1000, 32'd3);
        step();
        valid = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        step();
        chk("busy after mid-div reset", 64'(busy), 64'(1'b0));
        reset = 1'b0;
        rdchk("hi after reset", MFHI, '0);
        rdchk("lo after reset", MFLO, '0);
        step(); run("mult after reset", MULT, 32'd123, 32'd456, 0, 32'd0, 32'd56088);

        for (int i = 0; i < 16; i++) begin
            case ($urandom % 4)
                0: f = MULT;
                1: f = MULTU;
                2: f = DIV;
                default: f = DIVU;
            endcase
            a = $urandom;
            b = $urandom;
            if ($urandom % 5 == 0) b = '0;
            if ($urandom % 7 == 0) b = '1;
            if ($urandom % 6 == 0) a = 32'h8000_0000;
            if ($urandom % 3 == 0) b = $urandom % 64;
            model(f, a, b, eh, el);
            step();
            run($sformatf("rand%0d f=%b a=%h b=%h", i, f, a, b), f, a, b, 0, eh, el);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_control.md
# alu_muldiv_control

Parametrised ALU control for the single-cycle datapath, extended with an iterative multiply/divide sequencer and HI/LO registers. It decodes `alu_op`/`funct` into the 4-bit ALU operation code, as before. It also accepts MULT/MULTU/DIV/DIVU, runs them over multiple cycles, and raises `stall` so the PC/IF stage holds while a result is pending. It sits between the main control unit and the ALU/writeback mux.

## Interface
- `WIDTH`, default 32: datapath width; even, ≥4.
- `CNT_W`, default $clog2(WIDTH)+1: iteration counter width (derived localparam, not overridable).
- `clk`  in  1  rising-edge clock, sole clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `valid`  in  1  instruction in decode is real (not bubble).
- `alu_op`  in  3  main-control class code.
- `funct`  in  6  R-type function field.
- `rs_val`  in  WIDTH  operand A / dividend / mthi-mtlo source.
- `rt_val`  in  WIDTH  operand B / divisor.
- `aluctrl`  out  4  ALU operation code (combinational).
- `stall`  out  1  hold PC/IF/ID this cycle (combinational).
- `busy`  out  1  multiply/divide in progress (registered).
- `mf_valid`  out  1  mfhi/mflo selected; writeback takes `mf_data`.
- `mf_data`  out  WIDTH  HI for mfhi, LO for mflo, else 0.

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- `alu_op`: 000→ADD (lw/sw/addi), 001→SUB (beq), 010→from funct, 011→AND (andi), 100→OR (ori), 101→SLT (slti), others→0000.
- funct (alu_op=010): 100100 AND, 100101 OR, 100000/100001 ADD, 100010/100011 SUB, 101010 SLT, 100111 NOR, all others 0000.
- Muldiv funct (alu_op=010): 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo.
- HI/LO access (any muldiv funct) only when `valid`. With `busy`=1: `stall`=1, instruction not accepted. With `busy`=0: accepted.
- FSM states IDLE, MUL, DIV, FIX.
  - IDLE→MUL on accepted mult/multu; IDLE→DIV on accepted div/divu.
  - Operands latched as magnitudes (signed ops) plus result-sign flags; counter loaded with WIDTH.
  - MUL/DIV: one radix-2 step per cycle (shift-add / restoring shift-subtract); →FIX when counter reaches 0.
  - FIX: apply sign correction, write HI/LO, →IDLE.
- Signed divide: quotient truncates toward zero; remainder takes dividend's sign.
- INT_MIN / −1: LO=INT_MIN, HI=0.
- Divide by zero (signed or unsigned): HI=dividend, LO=all ones, same latency.
- mthi/mtlo accepted: HI/LO written at the end of that cycle.
- mfhi/mflo accepted: `mf_valid`=1, `mf_data` = current register value.
- Product is 2·WIDTH bits: HI = upper, LO = lower.
- Reset, including mid-operation: state IDLE, HI=LO=0, counter 0, `busy`=0, operation aborted, no partial HI/LO write.

## Timing
- `aluctrl`, `stall`, `mf_valid`, `mf_data`: combinational, zero latency.
- Reset values: `busy`=0; `mf_data`=0 (HI=LO=0); `stall` and `mf_valid` 0 unless a qualifying `valid` input is present.
- Start accepted in cycle T: `busy`=1 from T+1 through T+WIDTH+1 (WIDTH iterations + FIX). HI/LO visible at T+WIDTH+2.
- mfhi issued in T+1..T+WIDTH+1 stalls; re-presented at T+WIDTH+2 it returns the new value without stall.
- Back-to-back mult then div: second stalls until T+WIDTH+2, then starts.
- Non-muldiv instructions never stall; `aluctrl` stays valid while `busy` (independent ALU ops overlap).

## Structure
- Package `alu_ctrl_pkg`: ALU code constants, alu_op codes, funct codes, FSM state enum.
- Sub-module `muldiv_iter`: operand registers, counter, shift/add-sub datapath, sign fix, HI/LO. Top level holds decode, stall/accept logic and mf mux.

## Test plan
- Sweep every alu_op and every listed funct with `valid`=1, idle → exact `aluctrl` per tables; unlisted funct → 0000, `stall`=0.
- mult 7 × 0xFFFFFFFD (−3) → `busy` 33 cycles, then mfhi=0xFFFFFFFF, mflo=0xFFFFFFEB; multu 0xFFFFFFFF² → HI=0xFFFFFFFE, LO=0x00000001.
- div 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu 10 / 0 → HI=0x0000000A, LO=0xFFFFFFFF after 33 busy cycles.
- mfhi issued 1 cycle after mult start → `stall` high each cycle until T+34, then correct data; add issued meanwhile → `aluctrl`=0010, `stall`=0.
- `reset` pulsed at iteration 10 of div → `busy`=0 next cycle, mfhi/mflo return 0; new mult then completes normally.
